mips_lsu: RTL and testbench

//  Multi-cycle load/store unit for the MIPS CPU family. Accepts one memory op from the CPU core,

---
 rtl/mips_lsu_pkg.sv | 39 +++
 rtl/mips_lsu_if.sv | 41 ++++
 rtl/mips_lsu_lane.sv | 82 ++++++++
 rtl/mips_lsu.sv | 138 +++++++++++++
 tb/tb_mips_lsu.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit: FSM states, req_op opcodes and
// byte-strobe patterns.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRdw,
    StDone
  } lsu_state_e;

  // Low three bits of req_op; bit 3 is is_store.
  localparam logic [2:0] OpB   = 3'b000;
  localparam logic [2:0] OpH   = 3'b001;
  localparam logic [2:0] OpWl  = 3'b010;
  localparam logic [2:0] OpW   = 3'b011;
  localparam logic [2:0] OpBu  = 3'b100;
  localparam logic [2:0] OpHu  = 3'b101;
  localparam logic [2:0] OpWr  = 3'b110;
  localparam logic [2:0] OpBad = 3'b111;

  localparam logic [3:0] StrbNone   = 4'b0000;
  localparam logic [3:0] StrbAll    = 4'b1111;
  localparam logic [3:0] StrbLoHalf = 4'b0011;
  localparam logic [3:0] StrbHiHalf = 4'b1100;

  // Halfword ops need a[0]=0, full-word ops need a=0; unaligned and byte ops are never flagged.
  function automatic logic misaligned(logic [2:0] opc, logic [1:0] a);
    logic res;
    res = 1'b0;
    case (opc)
      OpH, OpHu: res = a[0];
      OpW:       res = (a != 2'b00);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Core-side request/response handshake and memory-bus signals of the load/store unit.
// slave is the LSU's view; master is the core plus memory driving it.
interface mips_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_rt;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] Address;
  logic                  MemWrite;
  logic                  MemRead;
  logic [31:0]           Write_data;
  logic [3:0]            Write_strb;
  logic                  Mem_Req_Ready;
  logic [31:0]           Read_data;
  logic                  Read_data_Valid;
  logic                  Read_data_Ready;

  modport slave (
    input  req_valid, req_op, req_addr, req_rt, resp_ready,
           Mem_Req_Ready, Read_data, Read_data_Valid,
    output req_ready, resp_valid, resp_data, resp_err,
           Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready
  );

  modport master (
    output req_valid, req_op, req_addr, req_rt, resp_ready,
           Mem_Req_Ready, Read_data, Read_data_Valid,
    input  req_ready, resp_valid, resp_data, resp_err,
           Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready
  );

endinterface

// File: rtl/mips_lsu_lane.sv
// Combinational byte-lane logic: store strobe/data steering and load extend/merge
// (including lwl/lwr) for a given op, byte offset a, rt and bus read word rd.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rt,
  input  logic [31:0] rd,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  sh_a;
  logic [4:0]  sh_na;

  always_comb begin
    strb   = StrbNone;
    wdata  = 32'h0;
    rdata  = 32'h0;
    byte_v = rd[{a, 3'b000} +: 8];
    half_v = a[1] ? rd[31:16] : rd[15:0];
    sh_a   = {a, 3'b000};
    // ~a == 3-a for a 2-bit offset
    sh_na  = {~a, 3'b000};

    if (op[3]) begin
      case (op[2:0])
        OpB, OpBu: begin
          strb  = 4'b0001 << a;
          wdata = {4{rt[7:0]}};
        end
        OpH, OpHu: begin
          strb  = a[1] ? StrbHiHalf : StrbLoHalf;
          wdata = {2{rt[15:0]}};
        end
        OpW: begin
          strb  = StrbAll;
          wdata = rt;
        end
        OpWl: begin
          strb  = StrbAll >> ~a;
          wdata = rt >> sh_na;
        end
        OpWr: begin
          strb  = StrbAll << a;
          wdata = rt << sh_a;
        end
        default: ;
      endcase
    end else begin
      case (op[2:0])
        OpB:  rdata = {{24{byte_v[7]}}, byte_v};
        OpBu: rdata = {24'h0, byte_v};
        OpH:  rdata = {{16{half_v[15]}}, half_v};
        OpHu: rdata = {16'h0, half_v};
        OpW:  rdata = rd;
        OpWl: begin
          case (a)
            2'd0:    rdata = {rd[7:0], rt[23:0]};
            2'd1:    rdata = {rd[15:0], rt[15:0]};
            2'd2:    rdata = {rd[23:0], rt[7:0]};
            default: rdata = rd;
          endcase
        end
        OpWr: begin
          case (a)
            2'd0:    rdata = rd;
            2'd1:    rdata = {rt[31:24], rd[31:8]};
            2'd2:    rdata = {rt[31:16], rd[31:16]};
            default: rdata = {rt[31:8], rd[31:24]};
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_lsu.sv
// Multi-cycle MIPS load/store unit: one op at a time over a valid/ready memory bus.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned h/w accesses with resp_err.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_lsu_if.slave            bus,
  output logic [CNT_WIDTH-1:0] perf_mem_cycles
);

  lsu_state_e            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           rt_q, rt_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  mips_lsu_lane u_lane (
    .op    (op_q),
    .a     (addr_q[1:0]),
    .rt    (rt_q),
    .rd    (bus.Read_data),
    .strb  (lane_strb),
    .wdata (lane_wdata),
    .rdata (lane_rdata)
  );

  always_comb begin
    state_d             = state_q;
    op_d                = op_q;
    addr_d              = addr_q;
    rt_d                = rt_q;
    data_d              = data_q;
    err_d               = err_q;
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.MemWrite        = 1'b0;
    bus.MemRead         = 1'b0;
    bus.Write_data      = 32'h0;
    bus.Write_strb      = StrbNone;
    bus.Read_data_Ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d   = bus.req_op;
          addr_d = bus.req_addr;
          rt_d   = bus.req_rt;
          data_d = 32'h0;
          err_d  = 1'b0;
          if (bus.req_op[2:0] == OpBad) begin
            state_d = StDone;
          end
`ifdef LSU_ALIGN_CHECK_EN
          else if (misaligned(bus.req_op[2:0], bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
          else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        bus.MemWrite = op_q[3];
        bus.MemRead  = ~op_q[3];
        if (op_q[3]) begin
          bus.Write_data = lane_wdata;
          bus.Write_strb = lane_strb;
        end
        // Read_data_Valid is deliberately not looked at here.
        if (bus.Mem_Req_Ready) begin
          state_d = op_q[3] ? StDone : StRdw;
        end
      end
      StRdw: begin
        bus.Read_data_Ready = 1'b1;
        if (bus.Read_data_Valid) begin
          data_d  = lane_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating count of cycles spent waiting on the bus.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == StReq || state_q == StRdw) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      addr_q  <= '0;
      rt_q    <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rt_q    <= rt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Address     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.resp_data   = data_q;
  // Never set without LSU_ALIGN_CHECK_EN, so resp_err stays 0 in that build.
  assign bus.resp_err    = err_q;
  assign perf_mem_cycles = cnt_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: directed ops push expected responses, a monitor pops and
// compares on resp_valid, and a memory responder checks bus fields and injects wait states.
module tb_mips_lsu;

  localparam int unsigned CntW   = 8;
  localparam int          CntMax = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CntW-1:0] perf;
  int              cyc = 0;
  int              compared = 0;
  int              mismatched = 0;

  mips_lsu_if #(.ADDR_WIDTH(32)) bus ();

  mips_lsu #(.ADDR_WIDTH(32), .CNT_WIDTH(CntW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .perf_mem_cycles (perf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cnt;
    int          lat;
    int          hold;
  } exp_t;

  typedef struct {
    bit          bus_on;
    bit          load;
    logic [31:0] addr_w;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          noise;
  } bus_t;

  exp_t sb[$];
  bus_t cur;
  int   req_left = 0;
  int   rd_left = 0;
  int   accept_cyc = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string exp);
    compared++;
    mismatched++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  // Memory responder
  always @(negedge clk) begin
    if (rst) begin
      bus.Mem_Req_Ready   = 1'b0;
      bus.Read_data_Valid = 1'b0;
    end else if (bus.MemRead || bus.MemWrite) begin
      if (!cur.bus_on) begin
        fail("bus_access", "MemRead/MemWrite high", "no bus access");
      end else begin
        chk("address", bus.Address, cur.addr_w);
        chk("memread", {31'h0, bus.MemRead}, {31'h0, cur.load});
        chk("memwrite", {31'h0, bus.MemWrite}, {31'h0, !cur.load});
        if (!cur.load) begin
          chk("write_strb", {28'h0, bus.Write_strb}, {28'h0, cur.strb});
          chk("write_data", bus.Write_data, cur.wdata);
        end
      end
      bus.Mem_Req_Ready = (req_left == 0);
      if (req_left > 0) req_left--;
      bus.Read_data_Valid = cur.noise;
      bus.Read_data       = 32'hDEADBEEF;
    end else if (bus.Read_data_Ready) begin
      bus.Mem_Req_Ready = 1'b0;
      if (rd_left == 0) begin
        bus.Read_data_Valid = 1'b1;
        bus.Read_data       = cur.rd;
      end else begin
        bus.Read_data_Valid = 1'b0;
        bus.Read_data       = 32'hDEADBEEF;
        rd_left--;
      end
    end else begin
      bus.Mem_Req_Ready   = 1'b0;
      bus.Read_data_Valid = cur.noise;
      bus.Read_data       = 32'hDEADBEEF;
    end
  end

  // Response monitor
  bit seen = 1'b0;
  int hold_left = 0;
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) begin
        fail("unexpected_resp", "resp_valid", "no response");
        bus.resp_ready = 1'b1;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          hold_left = sb[0].hold;
          chk("latency", cyc - accept_cyc, sb[0].lat);
        end
        if (hold_left > 0) begin
          bus.resp_ready = 1'b0;
          hold_left--;
        end else begin
          chk("resp_data", bus.resp_data, sb[0].data);
          chk("resp_err", {31'h0, bus.resp_err}, {31'h0, sb[0].err});
          chk("perf_cnt", {24'h0, perf}, sb[0].cnt);
          bus.resp_ready = 1'b1;
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      bus.resp_ready = 1'b0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rd, input int rw, input int dw, input bit noise,
                       input int hold, input logic [31:0] exp_data, input bit exp_err,
                       input bit bus_on, input logic [3:0] strb, input logic [31:0] wdata,
                       input bit push);
    exp_t e;
    int   n;
    int   inc;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) fail("req_ready_timeout", "0", "1");
    inc = bus_on ? (rw + 1 + (op[3] ? 0 : dw + 1)) : 0;
    exp_cnt = (exp_cnt + inc > CntMax) ? CntMax : exp_cnt + inc;
    cur = '{bus_on: bus_on, load: !op[3], addr_w: {addr[31:2], 2'b00}, strb: strb,
            wdata: wdata, rd: rd, noise: noise};
    req_left = rw;
    rd_left  = dw;
    e = '{data: exp_data, err: exp_err, cnt: exp_cnt, lat: 1 + inc, hold: hold};
    if (push) sb.push_back(e);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_rt    = rt;
    bus.req_valid = 1'b1;
    accept_cyc    = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (push) begin
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        fail("resp_timeout", "no response", "resp_valid");
        sb.delete();
        seen = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    cur = '{bus_on: 1'b0, load: 1'b0, addr_w: 32'h0, strb: 4'h0, wdata: 32'h0, rd: 32'h0,
            noise: 1'b0};
    bus.req_valid = 1'b0;
    bus.req_op = 4'h0;
    bus.req_addr = 32'h0;
    bus.req_rt = 32'h0;
    bus.resp_ready = 1'b0;
    bus.Mem_Req_Ready = 1'b0;
    bus.Read_data = 32'h0;
    bus.Read_data_Valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_mem_rw", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    chk("rst_rd_ready", {31'h0, bus.Read_data_Ready}, 32'h0);
    chk("rst_strb", {28'h0, bus.Write_strb}, 32'h0);
    chk("rst_perf", {24'h0, perf}, 32'h0);

    // op, addr, rt, rd, req_wait, rd_wait, noise, hold, data, err, bus, strb, wdata, push
    issue(4'b1000, 32'h103, 32'h000000AB, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b1000, 32'hABABABAB, 1);
    issue(4'b0001, 32'h102, 0, 32'h80017FFF, 0, 0, 0, 0, 32'hFFFF8001, 0, 1, 0, 0, 1);
    issue(4'b0101, 32'h102, 0, 32'h80017FFF, 0, 0, 0, 0, 32'h00008001, 0, 1, 0, 0, 1);
    issue(4'b0010, 32'h001, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 0, 32'hCCDD3344, 0, 1, 0, 0, 1);
    issue(4'b0110, 32'h002, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 0, 32'h1122AABB, 0, 1, 0, 0, 1);
    issue(4'b0010, 32'h003, 32'h11223344, 32'hAABBCCDD, 0, 0, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0, 1);
    // Bus waits plus stray Read_data_Valid during REQ/IDLE: 5 REQ + 4 RDW cycles
    issue(4'b0011, 32'h200, 0, 32'h12345678, 4, 3, 1, 0, 32'h12345678, 0, 1, 0, 0, 1);
    issue(4'b0000, 32'h101, 0, 32'h00008000, 0, 0, 0, 0, 32'hFFFFFF80, 0, 1, 0, 0, 1);
    issue(4'b0100, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 0, 32'h00000080, 0, 1, 0, 0, 1);
    issue(4'b1001, 32'h102, 32'h0000BEEF, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b1100, 32'hBEEFBEEF, 1);
    issue(4'b1010, 32'h101, 32'h11223344, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0011, 32'h00001122, 1);
    issue(4'b1110, 32'h101, 32'h11223344, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b1110, 32'h22334400, 1);
    issue(4'b0111, 32'h100, 32'h55555555, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
    issue(4'b1111, 32'h100, 32'h55555555, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
`ifdef LSU_ALIGN_CHECK_EN
    issue(4'b1011, 32'h102, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1);
    issue(4'b0001, 32'h101, 0, 32'h1234F00D, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1);
`else
    issue(4'b1011, 32'h102, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'hF, 32'hCAFEF00D, 1);
    issue(4'b0001, 32'h101, 0, 32'h1234F00D, 0, 0, 0, 0, 32'hFFFFF00D, 0, 1, 0, 0, 1);
`endif
    issue(4'b0011, 32'h104, 0, 32'h0BADF00D, 0, 0, 0, 2, 32'h0BADF00D, 0, 1, 0, 0, 1);

    // Reset while waiting for read data: the op is dropped and no response appears.
    issue(4'b0011, 32'h180, 0, 32'h99999999, 0, 50, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    n = 0;
    while (!bus.Read_data_Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Read_data_Ready) fail("reach_rdw", "no Read_data_Ready", "Read_data_Ready");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur.bus_on = 1'b0;
    exp_cnt = 0;
    chk("abort_rd_ready", {31'h0, bus.Read_data_Ready}, 32'h0);
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("abort_perf", {24'h0, perf}, 32'h0);
    repeat (3) @(negedge clk);
    issue(4'b0011, 32'h300, 0, 32'h55AA55AA, 0, 0, 0, 0, 32'h55AA55AA, 0, 1, 0, 0, 1);

    // Long waits push the counter past its maximum; it must stick at all-ones.
    issue(4'b0011, 32'h304, 0, 32'h01020304, 200, 100, 0, 0, 32'h01020304, 0, 1, 0, 0, 1);
    issue(4'b1000, 32'h300, 32'h0000005A, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0001, 32'h5A5A5A5A, 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
